ej32_mbus_arb: RTL and testbench

Four-requester arbiter and burst sequencer for the single 8-bit SPRAM bus of the eJ32 core. It shares the bus between the ROM boot loader, the load/store unit, the instruction fetch path and an output-buffer DMA drain. It turns each granted request into 1–4 consecutive byte beats with an auto-incrementing address. It routes each read byte back to its owner one cycle later.

---
 rtl/ej32_pkg.sv | 29 ++
 rtl/ej32_mbus_arb_if.sv | 36 +++
 rtl/ej32_rr_pick.sv | 40 ++++
 rtl/ej32_mbus_arb.sv | 120 ++++++++++++
 tb/tb_ej32_mbus_arb.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ej32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_pkg
//  Description : Shared types and constants for the eJ32 SPRAM bus arbiter.
//  Revision    : 1.0
// ============================================================================
`ifndef EJ32_ASZ
`define EJ32_ASZ 17
`endif

package ej32_pkg;

  localparam int ASZ_DEF  = `EJ32_ASZ;
  localparam int NREQ_DEF = 4;

  typedef enum logic [1:0] {
    RQ_BOOT = 2'd0,
    RQ_LS   = 2'd1,
    RQ_IF   = 2'd2,
    RQ_DMA  = 2'd3
  } rq_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_st_e;

endpackage
`default_nettype wire

// File: rtl/ej32_mbus_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_mbus_arb_if
//  Description : Requester and SPRAM signals of the eJ32 memory bus arbiter.
//  Revision    : 1.0
// ============================================================================
interface ej32_mbus_arb_if #(
  parameter int ASZ  = ej32_pkg::ASZ_DEF,
  parameter int NREQ = ej32_pkg::NREQ_DEF
);
  logic [NREQ-1:0]          req;
  logic [NREQ-1:0]          we;
  logic [NREQ-1:0][ASZ-1:0] addr;
  logic [NREQ-1:0][1:0]     len;
  logic [NREQ-1:0][7:0]     wdata;
  logic [NREQ-1:0]          ack;
  logic [NREQ-1:0]          done;
  logic [NREQ-1:0]          rvalid;
  logic [7:0]               rdata;
  logic [ASZ-1:0]           mem_a;
  logic                     mem_we;
  logic [7:0]               mem_vi;
  logic [7:0]               mem_vo;
  logic                     busy;

  modport slave (
    input  req, we, addr, len, wdata, mem_vo,
    output ack, done, rvalid, rdata, mem_a, mem_we, mem_vi, busy
  );

  modport master (
    output req, we, addr, len, wdata, mem_vo,
    input  ack, done, rvalid, rdata, mem_a, mem_we, mem_vi, busy
  );
endinterface
`default_nettype wire

// File: rtl/ej32_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_rr_pick
//  Description : Combinational round-robin pick among LS, IF and DMA.
//  Revision    : 1.0
// ============================================================================
module ej32_rr_pick
  import ej32_pkg::*;
(
  input  logic [3:1] i_req,
  input  rq_e        i_last,
  output rq_e        o_win,
  output logic       o_valid
);

  // Search begins at the requester after the previous winner.
  always_comb begin
    o_win   = RQ_LS;
    o_valid = |i_req;
    case (i_last)
      RQ_LS: begin
        if (i_req[2])      o_win = RQ_IF;
        else if (i_req[3]) o_win = RQ_DMA;
        else               o_win = RQ_LS;
      end
      RQ_IF: begin
        if (i_req[3])      o_win = RQ_DMA;
        else if (i_req[1]) o_win = RQ_LS;
        else               o_win = RQ_IF;
      end
      default: begin
        if (i_req[1])      o_win = RQ_LS;
        else if (i_req[2]) o_win = RQ_IF;
        else               o_win = RQ_DMA;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ej32_mbus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_mbus_arb
//  Description : Four-requester SPRAM arbiter issuing 1-4 beat byte bursts.
//  Revision    : 1.0
// ============================================================================
module ej32_mbus_arb
  import ej32_pkg::*;
#(
  parameter int ASZ  = ASZ_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            rst,
  ej32_mbus_arb_if.slave  bus
);

  arb_st_e         r_state, w_state_nx;
  rq_e             r_owner, w_owner_nx;
  rq_e             r_last,  w_last_nx;
  logic [1:0]      r_cnt,   w_cnt_nx;
  logic [1:0]      r_off,   w_off_nx;
  logic            r_rd_pend;
  rq_e             r_rd_own;

  rq_e             w_rr_win;
  logic            w_rr_valid;
  logic [NREQ-1:0] w_ack;
  logic [NREQ-1:0] w_done;
  logic [ASZ-1:0]  w_mem_a;
  logic            w_mem_we;
  logic [7:0]      w_mem_vi;

  ej32_rr_pick u_rr_pick (
    .i_req   (bus.req[3:1]),
    .i_last  (r_last),
    .o_win   (w_rr_win),
    .o_valid (w_rr_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_owner <= RQ_BOOT;
      r_last  <= RQ_DMA;
      r_cnt   <= 2'd0;
      r_off   <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_last  <= w_last_nx;
      r_cnt   <= w_cnt_nx;
      r_off   <= w_off_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_last_nx  = r_last;
    w_cnt_nx   = r_cnt;
    w_off_nx   = r_off;
    w_ack      = '0;
    w_done     = '0;
    w_mem_a    = '0;
    w_mem_we   = 1'b0;
    w_mem_vi   = 8'd0;
    case (r_state)
      ST_IDLE: begin
        // BOOT preempts the rotation and does not disturb its position.
        if (bus.req[0]) begin
          w_owner_nx = RQ_BOOT;
          w_cnt_nx   = bus.len[RQ_BOOT];
          w_off_nx   = 2'd0;
          w_state_nx = ST_BURST;
        end else if (w_rr_valid) begin
          w_owner_nx = w_rr_win;
          w_last_nx  = w_rr_win;
          w_cnt_nx   = bus.len[w_rr_win];
          w_off_nx   = 2'd0;
          w_state_nx = ST_BURST;
        end
      end
      default: begin
        w_ack[r_owner] = 1'b1;
        w_mem_a        = bus.addr[r_owner] + ASZ'(r_off);
        w_mem_we       = bus.we[r_owner];
        w_mem_vi       = bus.wdata[r_owner];
        w_off_nx       = r_off + 2'd1;
        w_cnt_nx       = r_cnt - 2'd1;
        if (r_cnt == 2'd0) begin
          w_done[r_owner] = 1'b1;
          w_state_nx      = ST_IDLE;
        end
      end
    endcase
  end

  // Read-return tracking runs regardless of state so the final byte lands in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_pend <= 1'b0;
      r_rd_own  <= RQ_BOOT;
    end else begin
      r_rd_pend <= (r_state == ST_BURST) && !bus.we[r_owner];
      r_rd_own  <= r_owner;
    end
  end

  assign bus.ack    = w_ack;
  assign bus.done   = w_done;
  assign bus.mem_a  = w_mem_a;
  assign bus.mem_we = w_mem_we;
  assign bus.mem_vi = w_mem_vi;
  assign bus.rdata  = bus.mem_vo;
  assign bus.busy   = (r_state == ST_BURST);
  assign bus.rvalid = r_rd_pend ? (NREQ'(1) << r_rd_own) : '0;

endmodule
`default_nettype wire

// File: tb/tb_ej32_mbus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ej32_mbus_arb
//  Description : Self-checking bench for ej32_mbus_arb against a burst model.
//  Revision    : 1.0
// ============================================================================
module tb_ej32_mbus_arb;

  localparam int ASZ  = 17;
  localparam int NREQ = 4;
  localparam int MASK = (1 << ASZ) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ej32_mbus_arb_if #(.ASZ(ASZ), .NREQ(NREQ)) bus ();

  ej32_mbus_arb #(.ASZ(ASZ), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] sram    [0:(1<<ASZ)-1];
  logic [7:0] ref_mem [0:(1<<ASZ)-1];

  always @(posedge clk) begin
    if (bus.mem_we) sram[bus.mem_a] <= bus.mem_vi;
    bus.mem_vo <= sram[bus.mem_a];
  end

  int errors = 0;
  int checks = 0;

  // Requester-side stimulus state.
  bit         act  [4];
  bit         hold [4];
  bit         t_we [4];
  int         t_addr [4];
  int         t_len  [4];
  logic [7:0] t_data [4][4];
  int         bidx   [4];
  bit         rand_en = 0;

  // Transaction-level reference model.
  bit         m_busy;
  int         m_own, m_beat, m_n, m_last;
  bit         m_rdp;
  int         m_rdo, m_rda;
  logic [3:0] p_ack, p_done, pr_dut_ack;
  logic [3:0] glog [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      bus.req[i]   = act[i];
      bus.we[i]    = t_we[i];
      bus.addr[i]  = t_addr[i][ASZ-1:0];
      bus.len[i]   = t_len[i][1:0];
      bus.wdata[i] = t_data[i][bidx[i] & 3];
    end
  endtask

  task automatic post(input int i, input bit w, input int a, input int l, input logic [7:0] d0);
    act[i] = 1; bidx[i] = 0; t_we[i] = w; t_addr[i] = a & MASK; t_len[i] = l;
    for (int k = 0; k < 4; k++) t_data[i][k] = d0 + 8'(k);
    p_ack[i] = 1'b0; p_done[i] = 1'b0;
  endtask

  task automatic new_txn(input int i);
    int a;
    a = ($urandom_range(0, 7) == 0) ? (MASK - $urandom_range(0, 2)) : int'($urandom_range(0, MASK));
    post(i, bit'($urandom_range(0, 1)), a, $urandom_range(0, 3), 8'($urandom));
    for (int k = 0; k < 4; k++) t_data[i][k] = 8'($urandom);
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = 3; m_rdp = 0; m_own = 0; m_beat = 0; m_n = 1;
    p_ack = '0; p_done = '0; pr_dut_ack = '0;
    for (int i = 0; i < 4; i++) begin act[i] = 0; hold[i] = 0; bidx[i] = 0; end
    drive();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".ack"},    32'(bus.ack),    0);
    chk({tag, ".done"},   32'(bus.done),   0);
    chk({tag, ".rvalid"}, 32'(bus.rvalid), 0);
    chk({tag, ".mem_a"},  32'(bus.mem_a),  0);
    chk({tag, ".mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, ".mem_vi"}, 32'(bus.mem_vi), 0);
    chk({tag, ".busy"},   32'(bus.busy),   0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // One bus cycle: requesters react to last cycle, model predicts, outputs are compared.
  task automatic cycle();
    logic [3:0] e_ack, e_done, e_rv;
    int         e_a;
    bit         e_we;
    logic [7:0] e_vi;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (p_done[i]) begin
        if (hold[i]) bidx[i] = 0; else act[i] = 0;
      end else if (p_ack[i]) begin
        bidx[i]++;
      end
      if (!act[i] && rand_en && $urandom_range(0, (i == 0) ? 15 : 3) == 0) new_txn(i);
    end
    drive();
    e_ack = '0; e_done = '0; e_a = 0; e_we = 0; e_vi = 8'd0;
    if (m_busy) begin
      e_ack[m_own]  = 1'b1;
      e_done[m_own] = (m_beat == m_n - 1);
      e_a  = (t_addr[m_own] + m_beat) & MASK;
      e_we = t_we[m_own];
      e_vi = t_data[m_own][m_beat];
    end
    e_rv = m_rdp ? (4'b0001 << m_rdo) : 4'b0000;
    @(negedge clk);
    chk("ack",    32'(bus.ack),    32'(e_ack));
    chk("done",   32'(bus.done),   32'(e_done));
    chk("mem_a",  32'(bus.mem_a),  32'(e_a));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("mem_vi", 32'(bus.mem_vi), 32'(e_vi));
    chk("busy",   32'(bus.busy),   32'(m_busy));
    chk("rvalid", 32'(bus.rvalid), 32'(e_rv));
    if (m_rdp) chk("rdata", 32'(bus.rdata), 32'(ref_mem[m_rda]));
    if (m_busy) chk("req_held_by_owner", 32'(bus.req[m_own]), 1);
    if (bus.ack != 4'b0 && pr_dut_ack == 4'b0) glog.push_back(bus.ack);
    pr_dut_ack = bus.ack;
    // Advance the model to the next cycle.
    if (m_busy && e_we) ref_mem[e_a] = e_vi;
    m_rdp = m_busy && !e_we;
    m_rda = e_a;
    m_rdo = m_own;
    if (m_busy) begin
      if (m_beat == m_n - 1) m_busy = 0; else m_beat++;
    end else begin
      int c;
      int w;
      w = -1;
      if (act[0]) w = 0;
      else begin
        c = m_last;
        for (int k = 0; k < 3; k++) begin
          c = (c == 3) ? 1 : c + 1;
          if (w < 0 && act[c]) w = c;
        end
        if (w > 0) m_last = w;
      end
      if (w >= 0) begin
        m_busy = 1; m_own = w; m_beat = 0; m_n = t_len[w] + 1;
      end
    end
    p_ack  = e_ack;
    p_done = e_done;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int guard;
    for (int a = 0; a < (1 << ASZ); a++) begin
      sram[a]    = 8'(a ^ (a >> 8) ^ 8'h5A);
      ref_mem[a] = sram[a];
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk_idle_outputs("por");
    rst = 1'b1;

    // Single uncontended read.
    post(1, 0, 'h1234, 0, 8'h00);
    glog.delete();
    run(4);
    chk("t1.ngrants", 32'(glog.size()), 1);
    if (glog.size() >= 1) chk("t1.grant0", 32'(glog[0]), 32'h2);

    // Four-beat DMA write burst.
    post(3, 1, 'h1400, 3, 8'hA0);
    run(7);
    for (int k = 0; k < 4; k++) chk("t2.sram", 32'(sram['h1400 + k]), 32'(8'hA0 + k));

    // Simultaneous BOOT, LS and IF after reset.
    do_reset();
    post(0, 0, 'h0100, 1, 8'h10);
    post(1, 0, 'h0200, 0, 8'h20);
    post(2, 1, 'h0300, 0, 8'h30);
    glog.delete();
    run(12);
    chk("t3.ngrants", 32'(glog.size()), 3);
    if (glog.size() == 3) begin
      chk("t3.grant0", 32'(glog[0]), 32'h1);
      chk("t3.grant1", 32'(glog[1]), 32'h2);
      chk("t3.grant2", 32'(glog[2]), 32'h4);
    end

    // Round-robin fairness with continuously held requests.
    do_reset();
    for (int i = 1; i < 4; i++) begin
      post(i, 0, 'h800 * i, 0, 8'h40);
      hold[i] = 1;
    end
    glog.delete();
    run(12);
    for (int i = 1; i < 4; i++) hold[i] = 0;
    run(4);
    chk("t4.ngrants_ge6", 32'(glog.size() >= 6), 1);
    if (glog.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("t4.order", 32'(glog[k]), 32'(4'b0010 << (k % 3)));
    end

    // Address wrap at the top of the space.
    post(2, 0, 'h1FFFF, 2, 8'h00);
    run(6);

    // Reset during beat 2 of a write burst.
    post(3, 1, 'h1500, 3, 8'hC0);
    guard = 0;
    while (!(m_busy && m_beat == 1) && guard < 10) begin
      cycle();
      guard++;
    end
    chk("t6.reached_beat2", 32'(guard < 10), 1);
    @(posedge clk);
    #2;
    chk("t6.we_before_rst", 32'(bus.mem_we), 1);
    rst = 1'b0;
    #1;
    chk_idle_outputs("t6.abort");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    post(1, 0, 'h10, 0, 8'h00);
    post(2, 0, 'h20, 0, 8'h00);
    post(3, 0, 'h30, 0, 8'h00);
    glog.delete();
    run(8);
    chk("t6.first_after_rst", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 32'h2);

    // Randomized traffic against the model.
    rand_en = 1;
    run(4000);
    rand_en = 0;
    run(30);
    for (int i = 0; i < 4; i++) chk("drain.idle", 32'(act[i]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
